// File: rtl/pwm_demodulator.sv
// Recovers per-symbol high-step counts from a thermometer-coded, MSB-first PWM bitstream.
// Define PWM_DEMOD_GLITCH_FILTER_EN for majority-of-three step sampling.
module pwm_demodulator #(
    parameter int unsigned CLKS_PER_STEP = 4,
    parameter int unsigned PWM_STEPS     = 64,
    parameter int unsigned LOCK_SYMBOLS  = 4,
    parameter int unsigned DUTY_W        = $clog2(PWM_STEPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    input  logic              duty_ready,
    output logic              locked,
    output logic              frame_err,
    output logic              overflow
);

    localparam int unsigned CNT_W  = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam int unsigned IDX_W  = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_SYMBOLS + 1);

    localparam logic [CNT_W-1:0]  CntMax   = CNT_W'(CLKS_PER_STEP - 1);
    localparam logic [CNT_W-1:0]  CntMid   = CNT_W'(CLKS_PER_STEP / 2);
    localparam logic [IDX_W-1:0]  IdxLast  = IDX_W'(PWM_STEPS - 1);
    localparam logic [GOOD_W-1:0] GoodLock = GOOD_W'(LOCK_SYMBOLS);
    localparam logic [GOOD_W-1:0] GoodPre  = GOOD_W'(LOCK_SYMBOLS - 1);

    localparam logic [0:0] StHunt    = 1'b0;
    localparam logic [0:0] StMeasure = 1'b1;

    logic              s_meta_q, s_q, s_dly_q;
    logic              rise;
    logic              samp_bit;
    logic              sample_pt;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DUTY_W-1:0] hcnt_q, hcnt_d;
    logic              seen_zero_q, seen_zero_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              locked_q, locked_d;
    logic              frame_err_q, frame_err_d;

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              duty_valid_q, duty_valid_d;
    logic              overflow_q, overflow_d;

    logic              sym_done;
    logic [DUTY_W-1:0] result;

    assign rise = s_q & ~s_dly_q;

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] CntEarly  = CNT_W'(CLKS_PER_STEP / 2 - 1);
    localparam logic [CNT_W-1:0] CntSample = CNT_W'(CLKS_PER_STEP / 2 + 1);

    logic smp_early_q, smp_early_d;
    logic smp_mid_q, smp_mid_d;

    always_comb begin
        smp_early_d = (cnt_q == CntEarly) ? s_q : smp_early_q;
        smp_mid_d   = (cnt_q == CntMid) ? s_q : smp_mid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            smp_early_q <= 1'b0;
            smp_mid_q   <= 1'b0;
        end else begin
            smp_early_q <= smp_early_d;
            smp_mid_q   <= smp_mid_d;
        end
    end

    // Vote across the three cycles centred on the nominal sample point.
    assign samp_bit = (smp_early_q & smp_mid_q) | (smp_early_q & s_q) | (smp_mid_q & s_q);
`else
    localparam logic [CNT_W-1:0] CntSample = CntMid;

    assign samp_bit = s_q;
`endif

    assign sample_pt = (cnt_q == CntSample);

    // Framing FSM and step/symbol counters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CntMax) ? '0 : cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        hcnt_d      = hcnt_q;
        seen_zero_d = seen_zero_q;
        good_d      = good_q;
        locked_d    = locked_q;
        frame_err_d = 1'b0;
        sym_done    = 1'b0;
        result      = hcnt_q + DUTY_W'(samp_bit);

        case (state_q)
            StHunt: begin
                if (rise) begin
                    cnt_d       = '0;
                    idx_d       = '0;
                    hcnt_d      = '0;
                    seen_zero_d = 1'b0;
                    good_d      = '0;
                    state_d     = StMeasure;
                end
            end
            StMeasure: begin
                if (sample_pt) begin
                    if (samp_bit && seen_zero_q) begin
                        // A high step after a low one breaks thermometer coding.
                        frame_err_d = 1'b1;
                        locked_d    = 1'b0;
                        good_d      = '0;
                        idx_d       = '0;
                        hcnt_d      = '0;
                        seen_zero_d = 1'b0;
                        state_d     = StHunt;
                    end else if (idx_q == IdxLast) begin
                        sym_done    = 1'b1;
                        idx_d       = '0;
                        hcnt_d      = '0;
                        seen_zero_d = 1'b0;
                        if (good_q < GoodLock) begin
                            good_d = good_q + GOOD_W'(1);
                        end
                        if (good_q >= GoodPre) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        hcnt_d = hcnt_q + DUTY_W'(samp_bit);
                        if (!samp_bit) begin
                            seen_zero_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StHunt;
        endcase
    end

    // Output register with valid/ready; a result arriving while stalled is dropped.
    always_comb begin
        duty_d       = duty_q;
        duty_valid_d = duty_valid_q;
        overflow_d   = overflow_q;
        if (sym_done) begin
            if (duty_valid_q && !duty_ready) begin
                overflow_d = 1'b1;
            end else begin
                duty_d       = result;
                duty_valid_d = 1'b1;
            end
        end else if (duty_valid_q && duty_ready) begin
            duty_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_meta_q     <= 1'b0;
            s_q          <= 1'b0;
            s_dly_q      <= 1'b0;
            state_q      <= StHunt;
            cnt_q        <= '0;
            idx_q        <= '0;
            hcnt_q       <= '0;
            seen_zero_q  <= 1'b0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            s_meta_q     <= pwm_in;
            s_q          <= s_meta_q;
            s_dly_q      <= s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            hcnt_q       <= hcnt_d;
            seen_zero_q  <= seen_zero_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            frame_err_q  <= frame_err_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = duty_valid_q;
    assign locked     = locked_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Self-checking bench for pwm_demodulator: a directed vector table, hand-written corner
// sequences, and random symbol streams checked against a step-level framing model.
module tb_pwm_demodulator;

    localparam int CPS   = 4;
    localparam int STEPS = 64;
    localparam int LOCK  = 4;
    localparam int DW    = 7;
    localparam int MID   = CPS / 2;

    typedef struct {
        int duty_in;
        int exp_duty;
        bit exp_lock;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pwm_in = 1'b0;
    logic          duty_ready = 1'b0;
    logic [DW-1:0] duty;
    logic          duty_valid;
    logic          locked;
    logic          frame_err;
    logic          overflow;

    pwm_demodulator #(
        .CLKS_PER_STEP(CPS),
        .PWM_STEPS    (STEPS),
        .LOCK_SYMBOLS (LOCK),
        .DUTY_W       (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .duty_valid(duty_valid),
        .duty_ready(duty_ready),
        .locked    (locked),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, sampled on the falling edge.
    int cyc = 0;
    int valid_cycles = 0;
    int got_duty[$];
    bit got_lock[$];
    int got_cyc[$];
    int ferr_hi = 0;
    int ferr_rise = 0;
    int ferr_cyc = 0;
    bit ferr_lock = 1'b0;
    bit ferr_prev = 1'b0;

    // Per-test bookkeeping and model outputs.
    int base_acc, base_ferr, base_ferr_hi, base_valid;
    bit step_q[$];
    int exp_q[$];
    bit exp_lock_q[$];
    int exp_ferr;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (duty_valid === 1'b1) valid_cycles++;
            if (duty_valid === 1'b1 && duty_ready === 1'b1) begin
                got_duty.push_back(int'(duty));
                got_lock.push_back(locked);
                got_cyc.push_back(cyc);
            end
            if (frame_err === 1'b1) begin
                ferr_hi++;
                ferr_lock = locked;
                ferr_cyc  = cyc;
                if (!ferr_prev) ferr_rise++;
            end
            ferr_prev = (frame_err === 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit v);
        @(posedge clk);
        #1 pwm_in = v;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pwm_in = 1'b0;
        repeat (4) tick(1'b0);
        rst = 1'b1;
        tick(1'b0);
        base_acc     = got_duty.size();
        base_ferr    = ferr_rise;
        base_ferr_hi = ferr_hi;
        base_valid   = valid_cycles;
        step_q.delete();
        exp_q.delete();
        exp_lock_q.delete();
        exp_ferr = 0;
    endtask

    task automatic add_sym(input int d);
        for (int i = 0; i < STEPS; i++) step_q.push_back(i < d);
    endtask

    task automatic add_pat(input logic [STEPS-1:0] p);
        for (int i = 0; i < STEPS; i++) step_q.push_back(p[i]);
    endtask

    // Expand steps into clock cycles; optionally force one cycle high inside a given step.
    task automatic play(input int glitch_step, input int max_steps);
        for (int i = 0; i < step_q.size() && i < max_steps; i++) begin
            for (int c = 0; c < CPS; c++) begin
                tick((i == glitch_step && c == MID + 1) ? 1'b1 : step_q[i]);
            end
        end
        repeat (8) tick(1'b0);
    endtask

    // Step-level framing model: hunt for a 0->1 step edge, then take 64-step windows;
    // a window must be ones-then-zeros, otherwise it is a framing error at the offending step.
    task automatic model_run();
        int n, pos, good, ones, err;
        bit hunting, zero;
        n = step_q.size();
        pos = 0;
        hunting = 1'b1;
        good = 0;
        exp_q.delete();
        exp_lock_q.delete();
        exp_ferr = 0;
        while (pos < n) begin
            if (hunting) begin
                if (step_q[pos] && (pos == 0 || !step_q[pos-1])) begin
                    hunting = 1'b0;
                    good = 0;
                end else begin
                    pos++;
                end
            end else if (pos + STEPS > n) begin
                pos = n;
            end else begin
                ones = 0;
                zero = 1'b0;
                err = -1;
                for (int j = 0; j < STEPS; j++) begin
                    if (err < 0) begin
                        if (step_q[pos+j]) begin
                            if (zero) err = j;
                            else ones++;
                        end else begin
                            zero = 1'b1;
                        end
                    end
                end
                if (err >= 0) begin
                    exp_ferr++;
                    hunting = 1'b1;
                    pos += err + 1;
                end else begin
                    exp_q.push_back(ones);
                    if (good < LOCK) good++;
                    exp_lock_q.push_back(good >= LOCK);
                    pos += STEPS;
                end
            end
        end
    endtask

    task automatic compare_exp(input string tag);
        int n;
        n = got_duty.size() - base_acc;
        check({tag, " result count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check($sformatf("%s duty[%0d]", tag, i), got_duty[base_acc+i], exp_q[i]);
            check($sformatf("%s locked[%0d]", tag, i), got_lock[base_acc+i], exp_lock_q[i]);
        end
        check({tag, " frame errors"}, ferr_rise - base_ferr, exp_ferr);
    endtask

    initial begin
        vec_t vecs[10];
        logic [STEPS-1:0] p;
        int d, n;

        for (int i = 0; i < 6; i++) vecs[i] = '{37, 37, (i >= 3)};
        vecs[6] = '{0, 0, 1'b1};
        vecs[7] = '{64, 64, 1'b1};
        vecs[8] = '{1, 1, 1'b1};
        vecs[9] = '{63, 63, 1'b1};

        // Reset held while the input toggles.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(i[0]);
        check("reset duty", duty, 0);
        check("reset duty_valid", duty_valid, 0);
        check("reset locked", locked, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overflow", overflow, 0);
        rst = 1'b1;
        pwm_in = 1'b0;
        base_valid = valid_cycles;
        base_ferr = ferr_rise;
        repeat (1000) tick(1'b0);
        check("idle no valid", valid_cycles - base_valid, 0);
        check("idle no frame_err", ferr_rise - base_ferr, 0);
        check("idle locked", locked, 0);

        // Vector table: 6x duty 37, then 0, 64, 1, 63 after lock.
        do_reset();
        duty_ready = 1'b1;
        foreach (vecs[i]) add_sym(vecs[i].duty_in);
        play(-1, 1 << 20);
        n = got_duty.size() - base_acc;
        check("table result count", n, 10);
        for (int i = 0; i < 10 && i < n; i++) begin
            check($sformatf("table duty[%0d]", i), got_duty[base_acc+i], vecs[i].exp_duty);
            check($sformatf("table locked[%0d]", i), got_lock[base_acc+i], vecs[i].exp_lock);
            if (i > 0) begin
                check($sformatf("table cadence[%0d]", i),
                      got_cyc[base_acc+i] - got_cyc[base_acc+i-1], STEPS * CPS);
            end
        end
        check("table frame_err", ferr_hi - base_ferr_hi, 0);
        check("table overflow", overflow, 0);

        // Framing violation after lock, then relock on duty 30.
        do_reset();
        duty_ready = 1'b1;
        for (int i = 0; i < 4; i++) add_sym(37);
        p = '0;
        for (int i = 0; i < 10; i++) p[i] = 1'b1;
        for (int i = 15; i < 18; i++) p[i] = 1'b1;
        add_pat(p);
        for (int i = 0; i < 4; i++) add_sym(30);
        play(-1, 1 << 20);
        exp_q = '{37, 37, 37, 37, 30, 30, 30, 30};
        exp_lock_q = '{0, 0, 0, 1, 0, 0, 0, 1};
        exp_ferr = 1;
        compare_exp("frame");
        check("frame pulse width", ferr_hi - base_ferr_hi, 1);
        check("frame locked drop", ferr_lock, 0);
        if (got_duty.size() - base_acc >= 4) begin
            check("frame err at 16th sample", ferr_cyc - got_cyc[base_acc+3], 16 * CPS);
        end
        check("frame relocked", locked, 1);

        // Back-pressure across two completions.
        do_reset();
        duty_ready = 1'b0;
        add_sym(20);
        add_sym(21);
        play(-1, 1 << 20);
        check("bp duty held", duty, 20);
        check("bp duty_valid", duty_valid, 1);
        check("bp overflow", overflow, 1);
        tick(1'b0);
        duty_ready = 1'b1;
        tick(1'b0);
        duty_ready = 1'b0;
        tick(1'b0);
        check("bp accepts", got_duty.size() - base_acc, 1);
        if (got_duty.size() > base_acc) check("bp accepted duty", got_duty[base_acc], 20);
        check("bp valid drops", duty_valid, 0);
        check("bp overflow sticky", overflow, 1);

        // Reset mid-symbol discards the partial symbol.
        do_reset();
        duty_ready = 1'b1;
        add_sym(37);
        play(-1, 30);
        do_reset();
        check("midreset overflow", overflow, 0);
        add_sym(25);
        play(-1, 1 << 20);
        exp_q = '{25};
        exp_lock_q = '{0};
        exp_ferr = 0;
        compare_exp("midreset");

        // Single-cycle glitch inside the low region of a duty-10 symbol.
        do_reset();
        duty_ready = 1'b1;
        add_sym(10);
        add_sym(10);
        play(20, 1 << 20);
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
        exp_q = '{10, 10};
        exp_lock_q = '{0, 0};
        exp_ferr = 0;
`else
        exp_q = '{10};
        exp_lock_q = '{0};
        exp_ferr = 1;
`endif
        compare_exp("glitch");

        // Random symbol streams, including occasional non-thermometer symbols.
        for (int b = 0; b < 3; b++) begin
            do_reset();
            duty_ready = 1'b1;
            for (int s = 0; s < 12; s++) begin
                d = int'($urandom_range(0, 9));
                if (d == 0) begin
                    d = int'($urandom_range(1, 60));
                    p = '0;
                    for (int i = 0; i < d; i++) p[i] = 1'b1;
                    p[$urandom_range(d + 1, STEPS - 1)] = 1'b1;
                    add_pat(p);
                end else if (d == 1) begin
                    add_sym(0);
                end else if (d == 2) begin
                    add_sym(STEPS);
                end else begin
                    add_sym(int'($urandom_range(0, STEPS)));
                end
            end
            model_run();
            play(-1, 1 << 20);
            compare_exp($sformatf("random%0d", b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
